op_sequencer: RTL and testbench

- Programmable sequencer that drives the matrix controller's `operation`, `enable` and `in_data` inputs, and consumes its `out_data`.
- Host preloads a short program of 32-bit operation words, then pulses `start`.
- Block issues each word for the correct duration: fixed window for multiply (opcode 1), streaming handshakes for serial page load (opcode 2) and readout (opcode 3).
- Sits between the host/DMA interface and the controller.

---
 rtl/op_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_op_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// Program-driven sequencer for the matrix controller: issues stored operation words
// with a fixed window (multiply) or a streaming handshake (page load / readout).
module op_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int MUL_CYCLES = 640,
    parameter int XFER_LEN   = 64,
    parameter int GAP_CYCLES = 2,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   pc,
    output logic [31:0]   operation,
    output logic          ctrl_enable,
    output logic [31:0]   ctrl_in_data,
    input  logic [31:0]   ctrl_out_data,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [31:0]   din_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [31:0]   dout_data
);

    localparam int MAXC = (MUL_CYCLES > XFER_LEN) ?
                          ((MUL_CYCLES > GAP_CYCLES) ? MUL_CYCLES : GAP_CYCLES) :
                          ((XFER_LEN > GAP_CYCLES) ? XFER_LEN : GAP_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MUL, S_LOAD, S_STORE, S_GAP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     pc_q, pc_d;
    logic [AW:0]     len_q, len_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            error_q, error_d;
    logic [AW:0]     pc_inc;

    logic [31:0]     mem [PROG_DEPTH];
    logic [31:0]     word_q;

    assign pc_inc = pc_q + 1'b1;
    assign pc     = pc_q;
    assign error  = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    // Read address follows next-pc so the word for pc is already registered during FETCH.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        word_q <= mem[pc_d[AW-1:0]];
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        error_d      = error_q;
        busy         = 1'b0;
        done         = 1'b0;
        operation    = '0;
        ctrl_enable  = 1'b0;
        ctrl_in_data = '0;
        din_ready    = 1'b0;
        dout_valid   = 1'b0;
        dout_data    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        len_d   = prog_len;
                        pc_d    = '0;
                        error_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                busy  = 1'b1;
                cnt_d = '0;
                unique case (word_q[3:0])
                    4'd0:    state_d = S_GAP;
                    4'd1:    state_d = S_MUL;
                    4'd2:    state_d = S_LOAD;
                    4'd3:    state_d = S_STORE;
                    default: begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_MUL: begin
                busy        = 1'b1;
                operation   = word_q;
                ctrl_enable = 1'b1;
                if (cnt_q == CW'(MUL_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                operation    = word_q;
                din_ready    = 1'b1;
                ctrl_in_data = din_data;
                ctrl_enable  = din_valid;
                if (din_valid) begin
                    if (cnt_q == CW'(XFER_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STORE: begin
                busy        = 1'b1;
                operation   = word_q;
                dout_valid  = 1'b1;
                dout_data   = ctrl_out_data;
                ctrl_enable = dout_ready;
                if (dout_ready) begin
                    if (cnt_q == CW'(XFER_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                // Opcode 0 with enable high gives the controller a clean edge between ops.
                busy        = 1'b1;
                ctrl_enable = 1'b1;
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    pc_d    = pc_inc;
                    state_d = (pc_inc == len_q) ? S_DONE : S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: randomized handshakes and background noise, checked cycle by
// cycle against an op-by-op schedule derived from the program contents.
module tb_op_sequencer;

    localparam int AW   = 4;
    localparam int MULN = 640;
    localparam int XFER = 64;
    localparam int GAPN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          busy, done, error;
    logic [AW:0]   pc;
    logic [31:0]   operation;
    logic          ctrl_enable;
    logic [31:0]   ctrl_in_data;
    logic [31:0]   ctrl_out_data;
    logic          din_valid, din_ready;
    logic [31:0]   din_data;
    logic          dout_valid, dout_ready;
    logic [31:0]   dout_data;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   prog_model [16];
    logic          exp_err;
    logic [AW:0]   exp_pc;
    int            busy_obs;
    int            last_cyc;
    int            last_en;

    always #5 clk = ~clk;

    op_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .pc           (pc),
        .operation    (operation),
        .ctrl_enable  (ctrl_enable),
        .ctrl_in_data (ctrl_in_data),
        .ctrl_out_data(ctrl_out_data),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .din_data     (din_data),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_data    (dout_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] b, input logic [31:0] d,
                            input logic [31:0] op, input logic [31:0] en,
                            input logic [31:0] dr, input logic [31:0] dv,
                            input logic [31:0] pcv);
        chk({tag, "_busy"},  32'(busy),        b);
        chk({tag, "_done"},  32'(done),        d);
        chk({tag, "_op"},    operation,        op);
        chk({tag, "_en"},    32'(ctrl_enable), en);
        chk({tag, "_dinr"},  32'(din_ready),   dr);
        chk({tag, "_doutv"}, 32'(dout_valid),  dv);
        chk({tag, "_pc"},    32'(pc),          pcv);
        chk({tag, "_err"},   32'(error),       32'(exp_err));
    endtask

    // Random traffic on every input; program writes and starts only while a run is in flight.
    task automatic noise(input bit in_run);
        din_valid     = 1'($urandom);
        din_data      = $urandom;
        dout_ready    = 1'($urandom);
        ctrl_out_data = $urandom;
        if (in_run) begin
            start     = (($urandom % 4) == 0);
            prog_we   = (($urandom % 4) == 0);
            prog_addr = AW'($urandom);
            prog_data = $urandom;
            prog_len  = (AW + 1)'($urandom);
        end else begin
            start   = 1'b0;
            prog_we = 1'b0;
        end
    endtask

    task automatic write_prog(input int a, input logic [31:0] d);
        noise(0);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        prog_model[a] = d;
    endtask

    // vmode: 0 random handshakes, 1 din_valid toggling from low, 2 dout_ready high.
    task automatic run_prog(input int len, input int vmode, input int stall_at);
        logic [31:0] w;
        logic [31:0] held;
        int          opc, xfers, cyc, en_cnt, stall_cnt;
        busy_obs = 0;
        last_cyc = 0;
        last_en  = 0;
        noise(0);
        start    = 1'b1;
        prog_len = (AW + 1)'(len);
        #1;
        chk_outs("idle", 0, 0, 0, 0, 0, 0, 32'(exp_pc));
        @(negedge clk);
        start = 1'b0;
        if (len > 0) begin
            exp_err = 1'b0;
            exp_pc  = '0;
        end
        for (int i = 0; i < len; i++) begin
            w   = prog_model[i];
            opc = int'(w[3:0]);
            noise(1);
            #1;
            chk_outs("fetch", 1, 0, 0, 0, 0, 0, i);
            busy_obs += int'(busy);
            @(negedge clk);
            if (opc > 3) begin
                exp_err = 1'b1;
                break;
            end
            if (opc == 1) begin
                for (int k = 0; k < MULN; k++) begin
                    noise(1);
                    #1;
                    chk_outs("mul", 1, 0, w, 1, 0, 0, i);
                    busy_obs += int'(busy);
                    @(negedge clk);
                end
            end else if (opc == 2) begin
                xfers = 0; cyc = 0; en_cnt = 0;
                while (xfers < XFER && cyc < 1000) begin
                    noise(1);
                    din_valid = (vmode == 1) ? 1'(cyc % 2) : 1'($urandom);
                    #1;
                    chk_outs("load", 1, 0, w, 32'(din_valid), 1, 0, i);
                    chk("load_data", ctrl_in_data, din_data);
                    en_cnt   += int'(ctrl_enable);
                    busy_obs += int'(busy);
                    if (din_valid) xfers++;
                    cyc++;
                    @(negedge clk);
                end
                chk("load_xfers", 32'(xfers), XFER);
                chk("load_en_cycles", 32'(en_cnt), XFER);
                last_cyc = cyc;
                last_en  = en_cnt;
            end else if (opc == 3) begin
                xfers = 0; cyc = 0; en_cnt = 0; stall_cnt = 0; held = '0;
                while (xfers < XFER && cyc < 1000) begin
                    noise(1);
                    if (stall_at >= 0 && xfers == stall_at && stall_cnt < 10) begin
                        dout_ready    = 1'b0;
                        ctrl_out_data = held;
                        stall_cnt++;
                    end else begin
                        held       = ctrl_out_data;
                        dout_ready = (vmode == 2) ? 1'b1 : 1'($urandom);
                    end
                    #1;
                    chk_outs("store", 1, 0, w, 32'(dout_ready), 0, 1, i);
                    chk("store_data", dout_data, ctrl_out_data);
                    en_cnt   += int'(ctrl_enable);
                    busy_obs += int'(busy);
                    if (dout_ready) xfers++;
                    cyc++;
                    @(negedge clk);
                end
                chk("store_xfers", 32'(xfers), XFER);
                chk("store_en_cycles", 32'(en_cnt), XFER);
                last_cyc = cyc;
                last_en  = en_cnt;
            end
            for (int g = 0; g < GAPN; g++) begin
                noise(1);
                #1;
                chk_outs("gap", 1, 0, 0, 1, 0, 0, i);
                busy_obs += int'(busy);
                @(negedge clk);
            end
            exp_pc = (AW + 1)'(i + 1);
        end
        noise(0);
        #1;
        chk_outs("done", 0, 1, 0, 0, 0, 0, 32'(exp_pc));
        @(negedge clk);
        noise(0);
        #1;
        chk_outs("after", 0, 0, 0, 0, 0, 0, 32'(exp_pc));
        $display("run len=%0d vmode=%0d busy_cycles=%0d pc=%0d error=%0d", len, vmode,
                 busy_obs, pc, error);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tmp;
        int          rlen;
        reset   = 1'b1;
        exp_err = 1'b0;
        exp_pc  = '0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        noise(0);
        repeat (3) @(negedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        $display("reset check done");
        reset = 1'b0;
        @(negedge clk);

        // Load, load, multiply, readout
        write_prog(0, 32'h2);
        write_prog(1, 32'h12);
        write_prog(2, 32'h0000_1101);
        write_prog(3, 32'h23);
        run_prog(4, 0, -1);

        // Back-to-back multiplies
        write_prog(0, 32'h1);
        write_prog(1, 32'h1);
        run_prog(2, 0, -1);
        chk("b2b_busy_total", 32'(busy_obs), 2 * (1 + MULN + GAPN));

        // Load with valid toggling every other cycle
        write_prog(0, 32'h2);
        run_prog(1, 1, -1);
        chk("toggle_load_cycles", 32'(last_cyc), 2 * XFER);
        chk("toggle_load_en", 32'(last_en), XFER);

        // Readout with a 10-cycle ready stall mid-stream
        write_prog(0, 32'h3);
        run_prog(1, 2, 20);
        chk("stall_store_cycles", 32'(last_cyc), XFER + 10);

        // Empty program: done next cycle, never busy
        run_prog(0, 0, -1);

        // Illegal opcode, then a valid start clears error
        write_prog(0, 32'h5);
        run_prog(1, 0, -1);
        repeat (3) begin
            noise(0);
            #1;
            chk("idle_err_sticky", 32'(error), 1);
            @(negedge clk);
        end
        write_prog(0, 32'h0);
        run_prog(1, 0, -1);

        // Reset in the middle of a multiply window
        write_prog(0, 32'h1);
        noise(0);
        start    = 1'b1;
        prog_len = 1;
        @(negedge clk);
        start   = 1'b0;
        exp_err = 1'b0;
        exp_pc  = '0;
        noise(0);
        #1;
        chk_outs("rst_fetch", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        repeat (100) begin
            noise(0);
            #1;
            chk_outs("rst_mul", 1, 0, 1, 1, 0, 0, 0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        noise(0);
        #1;
        chk_outs("rst_abort", 0, 0, 0, 0, 0, 0, 0);
        $display("reset mid-mul: operation=%h enable=%0d busy=%0d", operation, ctrl_enable, busy);
        reset = 1'b0;
        @(negedge clk);
        run_prog(1, 0, -1);

        // Random legal programs
        for (int r = 0; r < 2; r++) begin
            rlen = 1 + int'($urandom % 3);
            for (int i = 0; i < rlen; i++) begin
                tmp      = $urandom;
                tmp[3:0] = 4'($urandom % 4);
                write_prog(i, tmp);
            end
            run_prog(rlen, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
